// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-master data-port arbiter.
// The FSM state type is exported so the bench can observe it directly.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_RD_LATENCY = 1;
  localparam int DEFAULT_MAX_HOLD   = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection: round-robin on ties, unless the previous
// owner still holds an active lock, in which case it keeps the port.
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock_active,
  input  logic halt,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = !halt && (req0 || req1);
    winner = req1;
    if (req0 && req1) begin
      winner = lock_active ? last : ~last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave arbiter for the data-side memory/device port.
// Handshake: a master holds req and its command stable until the cycle after its one-cycle ack pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int MAX_HOLD   = DEFAULT_MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  halt,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  rw0,
  input  logic                  rw1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  s_en,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  busy,
  output logic                  grant,
  output arb_state_t            dbg_state
);

  localparam int LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LATENCY);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_t        state;
  logic              last;
  logic              lock_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LAT_W-1:0]  lat_cnt;

  logic req_last;
  logic lock_g;
  logic lock_active;
  logic pick_valid;
  logic pick_winner;

  // A lock only matters while its owner keeps asking and the hold budget lasts.
  assign req_last    = last ? req1 : req0;
  assign lock_g      = grant ? lock1 : lock0;
  assign lock_active = lock_q && (hold_cnt < HOLD_MAX) && req_last;

  arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last        (last),
    .lock_active (lock_active),
    .halt        (halt),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      grant    <= 1'b0;
      last     <= 1'b1;
      lock_q   <= 1'b0;
      hold_cnt <= '0;
      lat_cnt  <= '0;
      s_en     <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant   <= pick_winner;
            s_en    <= 1'b1;
            s_we    <= pick_winner ? rw1 : rw0;
            s_addr  <= pick_winner ? addr1 : addr0;
            s_wdata <= pick_winner ? wdata1 : wdata0;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          s_en <= 1'b0;
          s_we <= 1'b0;
          if (s_we) begin
            ack0  <= ~grant;
            ack1  <= grant;
            state <= ST_DONE;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - LAT_ONE;
          if (lat_cnt == LAT_ONE) begin
            if (grant) rdata1 <= s_rdata;
            else       rdata0 <= s_rdata;
            ack0  <= ~grant;
            ack1  <= grant;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          last   <= grant;
          lock_q <= lock_g;
          // Consecutive locked grants to the same master count up to the bound.
          if (lock_g && (grant == last)) begin
            hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_ONE;
          end else begin
            hold_cnt <= lock_g ? HOLD_ONE : '0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// cycle-count reference model with a memory-backed slave.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int L  = 3;
  localparam int MH = 4;

  logic        clk, reset_n, halt;
  logic        req0, req1, rw0, rw1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, s_en, s_we, busy, grant;
  logic [31:0] rdata0, rdata1, s_addr, s_wdata, s_rdata;
  arb_state_t  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(L), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n), .halt(halt),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .busy(busy), .grant(grant), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- slave model ----------------
  function automatic logic [31:0] init_val(input logic [11:0] i);
    return {20'h5A5A5, i};
  endfunction

  logic [31:0] slave_mem [0:4095];
  bit          written   [0:4095];
  logic [31:0] pipe      [0:L-1];
  logic [31:0] ref_mem   [0:4095];

  always @(posedge clk) begin
    if (s_en) begin
      if (s_we) begin
        slave_mem[s_addr[13:2]] <= s_wdata;
        written[s_addr[13:2]]   <= 1'b1;
      end
      pipe[0] <= written[s_addr[13:2]] ? slave_mem[s_addr[13:2]] : init_val(s_addr[13:2]);
    end
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign s_rdata = pipe[L-1];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int m, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic lk);
    if (m == 0) begin
      req0 = r; rw0 = w; addr0 = a; wdata0 = d; lock0 = lk;
    end else begin
      req1 = r; rw1 = w; addr1 = a; wdata1 = d; lock1 = lk;
    end
  endtask

  task automatic wait_ack(input int m, input int budget, output int got);
    got = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((m == 0 && ack0 === 1'b1) || (m == 1 && ack1 === 1'b1)) begin
        got = c;
        break;
      end
    end
    tests_run++;
    if (got < 0) begin
      tests_failed++;
      $display("FAIL ack_timeout_m%0d: got no ack, required one within %0d cycles", m, budget);
    end
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d);
    int got;
    tick();
    set_cmd(m, 1'b1, 1'b1, a, d, 1'b0);
    wait_ack(m, 20, got);
    tick();
    set_cmd(m, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic run_contention(input logic lk0, output int seq[6], output int n, output int dual);
    logic a0, a1;
    for (int k = 0; k < 6; k++) seq[k] = -1;
    n = 0;
    dual = 0;
    tick();
    set_cmd(0, 1'b1, 1'b1, 32'h3400, $urandom, lk0);
    set_cmd(1, 1'b1, 1'b1, 32'h3500, $urandom, 1'b0);
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      if (a0 === 1'b1 && a1 === 1'b1) dual++;
      if (a0 === 1'b1 || a1 === 1'b1) begin
        seq[n] = (a1 === 1'b1) ? 1 : 0;
        n++;
      end
      tick();
      if (a0 === 1'b1) wdata0 = $urandom;
      if (a1 === 1'b1) wdata1 = $urandom;
    end
    set_cmd(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    halt    = 1'b0;
    set_cmd(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if ({s_en, s_we, ack0, ack1, busy, grant} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 000000", {s_en, s_we, ack0, ack1, busy, grant});
    end
    tests_run++;
    if ({s_addr, s_wdata} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_slave_bus: got %h/%h, required 0/0", s_addr, s_wdata);
    end
    tests_run++;
    if ({rdata0, rdata1} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h/%h, required 0/0", rdata0, rdata1);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    tick();
    set_cmd(0, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    tests_run++;
    if (s_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_c0_s_en: got %b, required 0", s_en);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({s_en, s_we, grant, ack0, busy} !== 5'b11001) begin
      tests_failed++;
      $display("FAIL wr_c1_ctrl: got %b, required 11001", {s_en, s_we, grant, ack0, busy});
    end
    tests_run++;
    if (s_addr !== 32'h1000 || s_wdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL wr_c1_bus: got %h/%h, required 00001000/deadbeef", s_addr, s_wdata);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({ack0, ack1, s_en} !== 3'b100) begin
      tests_failed++;
      $display("FAIL wr_c2_ack: got %b, required 100", {ack0, ack1, s_en});
    end
    tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({ack0, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL wr_c3_idle: got %b, required 00", {ack0, busy});
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] prev_r0, got_r0, got_r1;
    int first;
    logic en_c1;
    do_write(0, 32'h2000, 32'h12345678);
    prev_r0 = rdata0;
    got_r0 = 'x;
    got_r1 = 'x;
    en_c1 = 1'bx;
    first = -1;
    tick();
    set_cmd(1, 1'b1, 1'b0, 32'h2000, '0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) en_c1 = s_en && !s_we && (s_addr == 32'h2000);
      if (ack1 === 1'b1) begin
        first = c;
        got_r0 = rdata0;
        got_r1 = rdata1;
        break;
      end
    end
    tick();
    set_cmd(1, 1'b0, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (en_c1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_access: got %b, required read strobe of 00002000 in cycle 1", en_c1);
    end
    tests_run++;
    if (first != 2 + L) begin
      tests_failed++;
      $display("FAIL rd_latency: got ack1 at cycle %0d, required %0d", first, 2 + L);
    end
    tests_run++;
    if (got_r1 !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL rd_data: got %h, required 12345678", got_r1);
    end
    tests_run++;
    if (got_r0 !== prev_r0) begin
      tests_failed++;
      $display("FAIL rd_other_rdata: got %h, required %h", got_r0, prev_r0);
    end
  endtask

  task automatic test_round_robin();
    int seq[6];
    int n, dual;
    int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
    // The previous transaction was served to master 1, so the first tie goes to master 0.
    run_contention(1'b0, seq, n, dual);
    tests_run++;
    if (n != 6 || dual != 0) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d acks (%0d dual), required 6 (0 dual)", n, dual);
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (seq[k] != exp_seq[k]) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: got %0d, required %0d", k, seq[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_lock_bound();
    int seq[6];
    int n, dual;
    int exp_seq[6] = '{0, 0, 0, 0, 1, 0};
    run_contention(1'b1, seq, n, dual);
    tests_run++;
    if (n != 6 || dual != 0) begin
      tests_failed++;
      $display("FAIL lock_count: got %0d acks (%0d dual), required 6 (0 dual)", n, dual);
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (seq[k] != exp_seq[k]) begin
        tests_failed++;
        $display("FAIL lock_grant_%0d: got %0d, required %0d", k, seq[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_halt();
    int ackc, got, en_seen;
    logic [31:0] r0;
    ackc = -1;
    r0 = 'x;
    en_seen = 0;
    tick();
    set_cmd(0, 1'b1, 1'b0, 32'h1000, '0, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    tests_run++;
    if ({s_en, s_we} !== 2'b10) begin
      tests_failed++;
      $display("FAIL halt_rd_access: got %b, required 10", {s_en, s_we});
    end
    tick();
    halt = 1'b1;
    set_cmd(1, 1'b1, 1'b1, 32'h3100, 32'hCAFEF00D, 1'b0);
    for (int c = 2; c < 12; c++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin
        ackc = c;
        r0 = rdata0;
        break;
      end
    end
    tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (ackc != 2 + L || r0 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL halt_rd_ack: got cycle %0d data %h, required cycle %0d data deadbeef", ackc, r0, 2 + L);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s_en !== 1'b0 || busy !== 1'b0) en_seen++;
      tick();
    end
    tests_run++;
    if (en_seen != 0) begin
      tests_failed++;
      $display("FAIL halt_hold: got %0d active cycles while halted, required 0", en_seen);
    end
    halt = 1'b0;
    @(negedge clk);
    tests_run++;
    if (s_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_release_c0: got s_en %b, required 0", s_en);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({s_en, s_we, grant} !== 3'b111) begin
      tests_failed++;
      $display("FAIL halt_release_grant: got %b, required 111", {s_en, s_we, grant});
    end
    wait_ack(1, 10, got);
    tick();
    set_cmd(1, 1'b0, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (rdata1 !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL halt_rdata1_kept: got %h, required 12345678", rdata1);
    end
  endtask

  task automatic test_reset_mid_op();
    int first, got;
    first = -1;
    do_write(0, 32'h3200, 32'h1);
    tick();
    set_cmd(0, 1'b1, 1'b1, 32'h3300, 32'hAAAA0000, 1'b0);
    set_cmd(1, 1'b1, 1'b1, 32'h3304, 32'hBBBB0000, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    tests_run++;
    if ({s_en, grant} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got %b, required 11", {s_en, grant});
    end
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({s_en, s_we, ack0, ack1, busy, grant} !== 6'b0 || s_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %b addr %h, required 000000 addr 0",
               {s_en, s_we, ack0, ack1, busy, grant}, s_addr);
    end
    tests_run++;
    if ({rdata0, rdata1} !== 64'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_rdata: got %h/%h, required 0/0", rdata0, rdata1);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        first = (ack1 === 1'b1) ? 1 : 0;
        break;
      end
    end
    tests_run++;
    if (first != 0) begin
      tests_failed++;
      $display("FAIL rst_first_tie: got master %0d, required 0", first);
    end
    tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0, 1'b0);
    wait_ack(1, 10, got);
    tick();
    set_cmd(1, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_random();
    bit          act[2], acked_prev[2], lockv[2];
    logic        rwv[2];
    logic [31:0] addrv[2], datav[2];
    logic [31:0] exp_rd[2];
    logic [11:0] ix;
    int  m_last, m_hold, m_win, m_acc, m_ack;
    bit  m_lockq, m_busy, done_now, exp_busy, lk;
    logic m_rw;
    logic [31:0] m_addr, m_data;
    logic e_en, e_a0, e_a1;

    reset_n = 1'b0;
    set_cmd(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    m_last = 1; m_hold = 0; m_lockq = 0; m_busy = 0; m_win = 0; m_acc = -1; m_ack = -1;
    m_rw = 1'b0; m_addr = '0; m_data = '0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; acked_prev[m] = 0; lockv[m] = 0; rwv[m] = 0; addrv[m] = '0; datav[m] = '0;
      exp_rd[m] = '0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if ((acked_prev[m] && $urandom_range(0, 1) == 1) ||
            (!acked_prev[m] && !act[m] && $urandom_range(0, 2) == 0 && cyc < 380)) begin
          ix       = 12'($urandom_range(0, 15));
          act[m]   = 1;
          rwv[m]   = 1'($urandom_range(0, 1));
          addrv[m] = {18'd0, ix, 2'b00};
          datav[m] = $urandom;
          lockv[m] = ($urandom_range(0, 2) == 0);
        end else if (acked_prev[m]) begin
          act[m] = 0;
        end
        acked_prev[m] = 0;
        set_cmd(m, act[m], rwv[m], addrv[m], datav[m], lockv[m]);
      end

      @(negedge clk);
      done_now = 0;
      exp_busy = m_busy;
      e_en = m_busy && (cyc == m_acc);
      e_a0 = m_busy && (cyc == m_ack) && (m_win == 0);
      e_a1 = m_busy && (cyc == m_ack) && (m_win == 1);
      tests_run++;
      if (s_en !== e_en || busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL rnd_en_busy @%0d: got %b%b, required %b%b", cyc, s_en, busy, e_en, exp_busy);
      end
      if (e_en) begin
        tests_run++;
        if (s_we !== m_rw || s_addr !== m_addr || (m_rw && s_wdata !== m_data)) begin
          tests_failed++;
          $display("FAIL rnd_access @%0d: got we %b %h/%h, required we %b %h/%h",
                   cyc, s_we, s_addr, s_wdata, m_rw, m_addr, m_data);
        end
      end
      tests_run++;
      if ({ack0, ack1} !== {e_a0, e_a1}) begin
        tests_failed++;
        $display("FAIL rnd_ack @%0d: got %b%b, required %b%b", cyc, ack0, ack1, e_a0, e_a1);
      end
      if (m_busy && cyc == m_ack) begin
        tests_run++;
        if (grant !== 1'(m_win)) begin
          tests_failed++;
          $display("FAIL rnd_grant @%0d: got %b, required %0d", cyc, grant, m_win);
        end
        if (m_rw) ref_mem[m_addr[13:2]] = m_data;
        else      exp_rd[m_win] = ref_mem[m_addr[13:2]];
        lk = lockv[m_win];
        if (lk && m_win == m_last) m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
        else                       m_hold = lk ? 1 : 0;
        m_lockq = lk;
        m_last  = m_win;
        m_busy  = 0;
        acked_prev[m_win] = 1;
        done_now = 1;
      end
      tests_run++;
      if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
        tests_failed++;
        $display("FAIL rnd_rdata @%0d: got %h/%h, required %h/%h", cyc, rdata0, rdata1, exp_rd[0], exp_rd[1]);
      end
      if (!m_busy && !done_now && (act[0] || act[1])) begin
        if (act[0] && act[1])
          m_win = (m_lockq && m_hold < MH && act[m_last]) ? m_last : 1 - m_last;
        else
          m_win = act[1] ? 1 : 0;
        m_rw   = rwv[m_win];
        m_addr = addrv[m_win];
        m_data = datav[m_win];
        m_acc  = cyc + 1;
        m_ack  = cyc + 2 + (m_rw ? 0 : L);
        m_busy = 1;
      end
    end
    tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 4096; k++) ref_mem[k] = init_val(12'(k));
    test_reset();
    test_single_write();
    test_read_latency();
    test_round_robin();
    test_lock_bound();
    test_halt();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter that shares the data-side memory/device port (data memory plus the memory-mapped serial and 7-segment devices) between the core's operand port (master 0) and a second bus master such as a loader or debug engine (master 1). It accepts requests via a req/ack handshake, selects one master by round-robin with an optional bounded lock, and sequences a single access on the slave port with a fixed, parameterised read latency. It sits between the masters and the existing address-decoded memory/device fabric, which sees a single point-to-point master.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `RD_LATENCY`, 1, cycles from the slave sampling `s_en` to valid `s_rdata`; must be ≥1.
- `MAX_HOLD`, 4, maximum consecutive locked grants to one master before a forced release.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `halt`  in  1  when high, no new grant is issued.
- `req0`, `req1`  in  1  request; held high until `ack` is seen.
- `rw0`, `rw1`  in  1  1 = write, 0 = read.
- `lock0`, `lock1`  in  1  request to keep the grant for the next access.
- `addr0`, `addr1`  in  ADDR_WIDTH  access address.
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_WIDTH  read result; held until that master's next read completes.
- `s_en`  out  1  slave access strobe.
- `s_we`  out  1  slave write enable; qualified by `s_en`.
- `s_addr`  out  ADDR_WIDTH  slave address.
- `s_wdata`  out  DATA_WIDTH  slave write data.
- `s_rdata`  in  DATA_WIDTH  slave read data.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  index of the master currently or last served.

## Operation
- **Reset.** On `reset_n`=0 at posedge: state IDLE, all outputs 0, `last`=1 (so master 0 wins the first tie), hold count 0.
- **IDLE.**
  - If `halt` is high, or no request is present, stay in IDLE.
  - Otherwise pick a winner:
    - If exactly one master requests, it wins.
    - If both request, the master ≠ `last` wins, except under an active lock.
  - Lock: if `lock_last` was sampled high at the previous DONE, hold count < `MAX_HOLD`, and `req_last` is high, then `last` wins.
  - Latch the winner's rw, addr and wdata, set `grant`, and go to ACCESS.
- **ACCESS (1 cycle).**
  - Drive `s_en`=1, `s_we`=rw, and `s_addr`/`s_wdata` from the latched values.
  - For a write, go to DONE.
  - For a read, load the counter with `RD_LATENCY` and go to WAIT.
- **WAIT.**
  - `s_en`=0 and `s_we`=0. `s_addr` holds its value.
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `s_rdata` into `rdata[grant]` at that edge and go to DONE.
- **DONE (1 cycle).**
  - `ack[grant]`=1 and `last`=grant.
  - Hold count: if `lock[grant]` is high and grant equals the previous grant, increment it (saturating at `MAX_HOLD`); otherwise set it to 1 (or 0 if the lock is low).
  - Go to IDLE.
- **Halt.** `halt` is checked only in IDLE. A transaction in flight always completes.
- **Handshake.** A master updates or drops req/cmd at the edge that ends its ack cycle. Any request seen in the next IDLE is treated as new.
- **Reset mid-transaction.** The transaction is abandoned with no ack, and `s_en` is low from the next cycle.
- The unused master's `rdata` never changes.

## Timing
- Request sampled in IDLE at cycle i:
  - ACCESS at i+1.
  - Write ack at i+2.
  - Read ack at i+2+`RD_LATENCY`, with rdata valid in the same cycle.
- Minimum turnaround: a write every 3 cycles, a read every 3+`RD_LATENCY` cycles.
- `s_en` is high for exactly one cycle per transaction. `s_we` is never high while `s_en` is low.
- `ack0` and `ack1` are never high in the same cycle.

## Structure
- State encodings (IDLE, ACCESS, WAIT, DONE as a 2-bit field) and the default `RD_LATENCY` go in `common.vh` as macros, alongside the existing bus constants.
- One sub-module, `arb_pick`: combinational winner selection from req0, req1, last, lock_active and halt. It outputs `valid` and `winner`.
- Latency counter width is $clog2(`RD_LATENCY`+1). Hold counter width is $clog2(`MAX_HOLD`+1).

## Test plan
- **Reset then single write.** req0=1, rw0=1, addr0=0x1000, wdata0=0xDEADBEEF at cycle 0 → `s_en`=`s_we`=1 with that address/data at cycle 1; `ack0` at cycle 2 only.
- **Read latency.** With `RD_LATENCY`=3, req1 read of 0x2000 while the slave returns 0x12345678 → `ack1` 5 cycles after the IDLE sample; `rdata1`=0x12345678; `rdata0` unchanged.
- **Round-robin.** req0 and req1 held continuously for 6 writes → grant sequence 0,1,0,1,0,1.
- **Lock bound.** `MAX_HOLD`=4 with lock0=1 held and req1 contending → four consecutive grants to master 0, then master 1, then master 0.
- **Halt.** `halt` raised during a master-0 read's WAIT → that read acks normally, and no `s_en` while halt is high. `halt` dropped → pending req1 is granted the next cycle.
- **Reset mid-op.** `reset_n`=0 in the ACCESS cycle → next cycle all outputs are 0 and no ack. The first tie after release goes to master 0.
